spectral_flux: RTL and testbench

- Computes per-frame positive spectral flux from a stream of N squared-magnitude bins, one bin per valid cycle.
- Each bin is compared with the same bin of the previous frame. Positive differences are summed into a total and into three bands (low/mid/high); the band is chosen by the current bin's magnitude.
- At frame end it emits the flux results, a frame-done pulse and a beat flag.
- Sits between the FFT magnitude stage and the beat/tempo logic.

---
 rtl/spectral_flux.sv | 123 ++++++++++++
 tb/tb_spectral_flux.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/spectral_flux.sv
// Per-frame positive spectral flux over N squared-magnitude bins, split into
// low/mid/high bands by the current bin's magnitude, with a beat flag at frame end.
module spectral_flux #(
  parameter int W               = 16,
  parameter int N               = 8,
  parameter int MAX_FLUX_LENGTH = 32,
  parameter int LOW_MAX         = 512,
  parameter int MID_MAX         = 1024,
  parameter int BEAT_THRESH     = 2048
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mag_valid,
  input  logic [W-1:0]               mag_sq,
  output logic [MAX_FLUX_LENGTH-1:0] flux_value,
  output logic                       flux_valid,
  output logic                       beat_valid,
  output logic                       frame_done,
  output logic [MAX_FLUX_LENGTH-1:0] flux_low,
  output logic [MAX_FLUX_LENGTH-1:0] flux_mid,
  output logic [MAX_FLUX_LENGTH-1:0] flux_high,
  output logic [MAX_FLUX_LENGTH-1:0] flux_accum
);

  localparam int F  = MAX_FLUX_LENGTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  // Sum width covers the worst case of a full accumulator plus a full diff.
  localparam int SW = ((F > W) ? F : W) + 1;
  localparam logic [SW-1:0] SAT    = SW'({F{1'b1}});
  localparam logic [SW-1:0] BEAT_T = SW'(BEAT_THRESH);
  localparam logic [W-1:0]  LOW_T  = W'(LOW_MAX);
  localparam logic [W-1:0]  MID_T  = W'(MID_MAX);
  localparam logic [IW-1:0] LAST   = IW'(N - 1);

  logic [IW-1:0] idx_q;
  logic [W-1:0]  prev_q [N];
  logic [F-1:0]  total_q, low_q, mid_q, high_q, prev_total_q;
  logic [F-1:0]  value_q, flow_q, fmid_q, fhigh_q;
  logic          fvalid_q, beat_q, done_q;

  logic [W-1:0]  prev_bin, diff;
  logic [SW-1:0] contrib;
  logic          in_low, in_mid, frame_end, beat_d;
  logic [F-1:0]  total_d, low_d, mid_d, high_d;

  function automatic logic [F-1:0] sat_add(input logic [F-1:0] a, input logic [SW-1:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + b;
    return (s > SAT) ? {F{1'b1}} : s[F-1:0];
  endfunction

  always_comb begin
    prev_bin  = prev_q[idx_q];
    diff      = (mag_sq > prev_bin) ? (mag_sq - prev_bin) : '0;
    // DC bin refreshes its history but never adds flux.
    contrib   = (idx_q != '0) ? SW'(diff) : '0;
    in_low    = (mag_sq < LOW_T);
    in_mid    = !in_low && (mag_sq < MID_T);
    total_d   = sat_add(total_q, contrib);
    low_d     = in_low ? sat_add(low_q, contrib) : low_q;
    mid_d     = in_mid ? sat_add(mid_q, contrib) : mid_q;
    high_d    = (!in_low && !in_mid) ? sat_add(high_q, contrib) : high_q;
    frame_end = mag_valid && (idx_q == LAST);
    beat_d    = (SW'(total_d) > BEAT_T) && (total_d > prev_total_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q        <= '0;
      for (int i = 0; i < N; i++) prev_q[i] <= '0;
      total_q      <= '0;
      low_q        <= '0;
      mid_q        <= '0;
      high_q       <= '0;
      prev_total_q <= '0;
      value_q      <= '0;
      flow_q       <= '0;
      fmid_q       <= '0;
      fhigh_q      <= '0;
      fvalid_q     <= 1'b0;
      beat_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      fvalid_q <= 1'b0;
      beat_q   <= 1'b0;
      done_q   <= 1'b0;
      if (mag_valid) begin
        prev_q[idx_q] <= mag_sq;
        if (frame_end) begin
          value_q      <= total_d;
          flow_q       <= low_d;
          fmid_q       <= mid_d;
          fhigh_q      <= high_d;
          fvalid_q     <= 1'b1;
          done_q       <= 1'b1;
          beat_q       <= beat_d;
          prev_total_q <= total_d;
          total_q      <= '0;
          low_q        <= '0;
          mid_q        <= '0;
          high_q       <= '0;
          idx_q        <= '0;
        end else begin
          total_q <= total_d;
          low_q   <= low_d;
          mid_q   <= mid_d;
          high_q  <= high_d;
          idx_q   <= idx_q + 1'b1;
        end
      end
    end
  end

  assign flux_value = value_q;
  assign flux_low   = flow_q;
  assign flux_mid   = fmid_q;
  assign flux_high  = fhigh_q;
  assign flux_valid = fvalid_q;
  assign beat_valid = beat_q;
  assign frame_done = done_q;
  assign flux_accum = total_q;

endmodule

// File: tb/tb_spectral_flux.sv
// Bench for spectral_flux: a 32-bit and a 12-bit (saturating) instance share one
// stimulus stream and are checked against a frame-level arithmetic model.
module tb_spectral_flux;
  localparam int W = 16;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset, mag_valid;
  logic [W-1:0] mag_sq;

  logic [31:0] fv0, fl0, fm0, fh0, fa0;
  logic        fval0, bv0, fd0;
  logic [11:0] fv1, fl1, fm1, fh1, fa1;
  logic        fval1, bv1, fd1;

  always #5 clk = ~clk;

  spectral_flux #(.W(W), .N(N), .MAX_FLUX_LENGTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .mag_valid(mag_valid), .mag_sq(mag_sq),
    .flux_value(fv0), .flux_valid(fval0), .beat_valid(bv0), .frame_done(fd0),
    .flux_low(fl0), .flux_mid(fm0), .flux_high(fh0), .flux_accum(fa0)
  );

  spectral_flux #(.W(W), .N(N), .MAX_FLUX_LENGTH(12)) u_dut12 (
    .clk(clk), .reset(reset), .mag_valid(mag_valid), .mag_sq(mag_sq),
    .flux_value(fv1), .flux_valid(fval1), .beat_valid(bv1), .frame_done(fd1),
    .flux_low(fl1), .flux_mid(fm1), .flux_high(fh1), .flux_accum(fa1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: per-bin history, running sums per instance.
  longint unsigned prev_m [N];
  int              idx_m;
  longint unsigned run_t [2], run_l [2], run_m [2], run_h [2], prev_tot [2];
  longint unsigned maxv [2] = '{64'hFFFF_FFFF, 64'hFFF};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned sat(input longint unsigned v, input longint unsigned m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) prev_m[i] = 0;
    idx_m = 0;
    for (int k = 0; k < 2; k++) begin
      run_t[k] = 0; run_l[k] = 0; run_m[k] = 0; run_h[k] = 0; prev_tot[k] = 0;
    end
  endtask

  task automatic do_reset();
    mag_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    chk("rst_value", fv0, 0);
    chk("rst_accum", fa0, 0);
    chk("rst_pulses", {fval0, bv0, fd0, fval1, bv1, fd1}, 0);
    chk("rst_value12", fv1, 0);
    reset = 1'b0;
    model_reset();
  endtask

  // Presents one bin at the current negedge, checks at the following negedge,
  // then optionally idles for gap cycles.
  task automatic step(input int unsigned x, input int gap);
    longint unsigned xl, p, d;
    bit              done;
    bit              beat_e [2];
    longint unsigned ev [2], el [2], em [2], eh [2];
    xl        = x;
    mag_valid = 1'b1;
    mag_sq    = x[W-1:0];
    p         = prev_m[idx_m];
    d         = (xl > p) ? xl - p : 0;
    prev_m[idx_m] = xl;
    for (int k = 0; k < 2; k++) begin
      if (idx_m != 0) begin
        run_t[k] = sat(run_t[k] + d, maxv[k]);
        if (xl < 512)       run_l[k] = sat(run_l[k] + d, maxv[k]);
        else if (xl < 1024) run_m[k] = sat(run_m[k] + d, maxv[k]);
        else                run_h[k] = sat(run_h[k] + d, maxv[k]);
      end
    end
    done = (idx_m == N - 1);
    if (done) begin
      for (int k = 0; k < 2; k++) begin
        ev[k] = run_t[k]; el[k] = run_l[k]; em[k] = run_m[k]; eh[k] = run_h[k];
        beat_e[k]   = (run_t[k] > 2048) && (run_t[k] > prev_tot[k]);
        prev_tot[k] = run_t[k];
        run_t[k] = 0; run_l[k] = 0; run_m[k] = 0; run_h[k] = 0;
      end
      idx_m = 0;
    end else begin
      idx_m++;
    end
    @(negedge clk);
    chk("flux_valid", fval0, done);
    chk("frame_done", fd0, done);
    chk("flux_valid12", fval1, done);
    if (done) begin
      chk("flux_value", fv0, ev[0]);
      chk("flux_low", fl0, el[0]);
      chk("flux_mid", fm0, em[0]);
      chk("flux_high", fh0, eh[0]);
      chk("beat_valid", bv0, beat_e[0]);
      chk("flux_value12", fv1, ev[1]);
      chk("flux_low12", fl1, el[1]);
      chk("flux_mid12", fm1, em[1]);
      chk("flux_high12", fh1, eh[1]);
      chk("beat_valid12", bv1, beat_e[1]);
      chk("accum_cleared", fa0, 0);
    end else begin
      chk("beat_idle", bv0, 0);
      chk("flux_accum", fa0, run_t[0]);
      chk("flux_accum12", fa1, run_t[1]);
    end
    if (gap > 0) begin
      mag_valid = 1'b0;
      repeat (gap) @(negedge clk);
      chk("pulse_in_gap", {fval0, bv0, fd0}, 0);
    end
  endtask

  task automatic idle(input int n);
    mag_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int unsigned ramp [N] = '{100, 150, 200, 250, 300, 350, 400, 450};
  int unsigned mixd [N] = '{100, 700, 1500, 100, 700, 1500, 100, 700};

  initial begin
    reset = 1'b1; mag_valid = 1'b0; mag_sq = '0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    for (int i = 0; i < N; i++) step(500, 0);
    chk("f1_low", fl0, 3500);
    chk("f1_value", fv0, 3500);
    for (int i = 0; i < N; i++) step(ramp[i], 0);
    chk("f2_value", fv0, 0);
    for (int i = 0; i < N; i++) step(mixd[i], 0);
    chk("f3_mid", fm0, 1200);
    chk("f3_high", fh0, 2450);
    chk("f3_value", fv0, 3650);
    idle(3);
    chk("hold_value", fv0, 3650);

    for (int i = 0; i < N; i++) step(500, 0);
    for (int i = 0; i < N; i++) step(500, 3);
    chk("repeat_zero", fv0, 0);

    for (int i = 0; i < 4; i++) step(700, 0);
    do_reset();
    for (int i = 0; i < N; i++) step(500, (i == 3) ? 2 : 0);
    chk("post_reset_low", fl0, 3500);

    for (int f = 0; f < 15; f++) begin
      for (int i = 0; i < N; i++) begin
        int unsigned v;
        case ($urandom_range(0, 3))
          0:       v = $urandom_range(0, 511);
          1:       v = $urandom_range(512, 1023);
          2:       v = $urandom_range(1024, 65535);
          default: v = $urandom_range(0, 4000);
        endcase
        step(v, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
    end

    idle(2);
    do_reset();
    for (int i = 0; i < N; i++) step(32'hFFFF, 0);
    chk("sat_value12", fv1, 12'hFFF);
    chk("sat_high12", fh1, 12'hFFF);
    chk("sat_value32", fv0, 7 * 65535);
    for (int i = 0; i < N; i++) step(32'hFFFF, 1);
    chk("sat_second_zero", fv1, 0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
